// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage PC generator.
// Optional feature macro: PC_MISALIGN_TRAP_EN (see pc_gen_unit).
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } state_e;

    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_BR,
        SRC_FLUSH,
        SRC_PEND,
        SRC_TRAP
    } pc_src_e;

    localparam int INSTR_BYTES_DEF = 4;
    localparam int ALIGN_BITS      = $clog2(INSTR_BYTES_DEF);

    // Mask of the byte-offset bits below the instruction alignment.
    function automatic logic [63:0] low_mask(int unsigned ib);
        return 64'(ib - 1);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: hazard/redirect inputs, fetch address outputs.
// master = pipeline control side, slave = the PC generator.
interface pc_gen_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush_valid;
    logic [XLEN-1:0]  flush_target;
    logic             br_valid;
    logic [XLEN-1:0]  br_target;
    logic [XLEN-1:0]  pc_out;
    logic [XLEN-1:0]  pc_plus;
    logic             pc_valid;
    logic             br_pending;
    logic             misalign;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output stall, flush_valid, flush_target,
        output br_valid, br_target,
        input  pc_out, pc_plus, pc_valid,
        input  br_pending, misalign, fetch_count
    );

    modport slave (
        input  stall, flush_valid, flush_target,
        input  br_valid, br_target,
        output pc_out, pc_plus, pc_valid,
        output br_pending, misalign, fetch_count
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry holding register for a branch target that arrived during a stall.
// clear has priority over load; pending drives br_pending.
module pc_redirect_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] target_in,
    output logic [XLEN-1:0] target,
    output logic            pending
);

    logic [XLEN-1:0] target_q, target_d;
    logic            pending_q, pending_d;

    always_comb begin
        target_d  = target_q;
        pending_d = pending_q;
        if (clear) begin
            pending_d = 1'b0;
        end else if (load) begin
            target_d  = target_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            target_q  <= target_d;
            pending_q <= pending_d;
        end
    end

    assign target  = target_q;
    assign pending = pending_q;

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage PC generator: flush > branch > sequential, stall-held branches.
// Define PC_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VECTOR.
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h80),
    parameter int              CNT_W        = 16
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = (INSTR_BYTES > 1);
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(low_mask(INSTR_BYTES));
    localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_d;

    pc_src_e          src;
    logic [XLEN-1:0]  tgt_raw;
    logic             buf_load;
    logic             buf_clear;
    logic             cnt_en;
    logic [XLEN-1:0]  pend_target;
    logic             pend_valid;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .target_in (bus.br_target),
        .target    (pend_target),
        .pending   (pend_valid)
    );

    always_comb begin
        state_d   = state_q;
        src       = SRC_HOLD;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.flush_valid) begin
                    src = SRC_FLUSH;
                end else if (!bus.stall) begin
                    cnt_en = valid_q;
                    src    = bus.br_valid ? SRC_BR : SRC_SEQ;
                end else if (bus.br_valid) begin
                    buf_load = 1'b1;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (bus.flush_valid) begin
                    src       = SRC_FLUSH;
                    buf_clear = 1'b1;
                    state_d   = RUN;
                end else if (bus.stall) begin
                    buf_load = bus.br_valid;
                end else begin
                    src       = SRC_PEND;
                    buf_clear = 1'b1;
                    cnt_en    = valid_q;
                    state_d   = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Redirect targets are alignment-checked at the edge that applies them.
    always_comb begin
        tgt_raw = '0;
        unique case (src)
            SRC_FLUSH: tgt_raw = bus.flush_target;
            SRC_BR:    tgt_raw = bus.br_target;
            SRC_PEND:  tgt_raw = pend_target;
            default:   tgt_raw = '0;
        endcase
        mis_d = TRAP_EN && ((tgt_raw & LOW_MASK) != '0);
    end

    always_comb begin
        pc_d = pc_q;
        if (mis_d) begin
            pc_d = TRAP_VECTOR;
        end else begin
            unique case (src)
                SRC_SEQ:   pc_d = pc_q + STEP;
                SRC_BR,
                SRC_FLUSH,
                SRC_PEND:  pc_d = tgt_raw & ~LOW_MASK;
                SRC_TRAP:  pc_d = TRAP_VECTOR;
                default:   pc_d = pc_q;
            endcase
        end
        valid_d = (state_q == BOOT) ? 1'b1 : valid_q;
        cnt_d   = cnt_q + CNT_W'(cnt_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= mis_d;
        end
    end

    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc_out      = pc_q;
    assign bus.pc_plus     = pc_q + STEP;
    assign bus.pc_valid    = valid_q;
    assign bus.br_pending  = pend_valid;
    assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios plus random traffic.
// A queue of expected outputs is filled by the driver and drained by a monitor.
module tb_pc_gen_unit;

    localparam int          XLEN  = 32;
    localparam int          IB    = 4;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RV    = 32'h0;
    localparam logic [31:0] TV    = 32'h80;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_gen_unit #(
        .XLEN         (XLEN),
        .INSTR_BYTES  (IB),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        bit          valid;
        bit          pend;
        bit          mis;
        int unsigned cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, described by behaviour rather than encoding.
    bit          m_booting;
    bit          m_valid;
    bit          m_pend;
    bit          m_mis;
    logic [31:0] m_pc;
    logic [31:0] m_pt;
    int unsigned m_cnt;

    function automatic void take(logic [31:0] t);
        if (TRAP && (t % IB) != 0) begin
            m_pc  = TV;
            m_mis = 1'b1;
        end else begin
            m_pc = t - (t % IB);
        end
    endfunction

    function automatic void count_fetch();
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
    endfunction

    function automatic void model(bit r, bit s, bit fv, logic [31:0] ft,
                                  bit bv, logic [31:0] bt);
        m_mis = 1'b0;
        if (r) begin
            m_pc      = RV;
            m_valid   = 1'b0;
            m_pend    = 1'b0;
            m_cnt     = 0;
            m_booting = 1'b1;
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_valid   = 1'b1;
        end else if (fv) begin
            take(ft);
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (s) begin
                if (bv) m_pt = bt;
            end else begin
                take(m_pt);
                m_pend = 1'b0;
                count_fetch();
            end
        end else if (!s) begin
            count_fetch();
            if (bv) take(bt);
            else m_pc = m_pc + 32'(IB);
        end else if (bv) begin
            m_pt   = bt;
            m_pend = 1'b1;
        end
    endfunction

    task automatic step(bit r, bit s, bit fv, logic [31:0] ft,
                        bit bv, logic [31:0] bt);
        exp_t e;
        rst              = r;
        bus.stall        = s;
        bus.flush_valid  = fv;
        bus.flush_target = ft;
        bus.br_valid     = bv;
        bus.br_target    = bt;
        model(r, s, fv, ft, bv, bt);
        e.pc    = m_pc;
        e.valid = m_valid;
        e.pend  = m_pend;
        e.mis   = m_mis;
        e.cnt   = m_cnt;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_out", bus.pc_out, e.pc);
            chk("pc_plus", bus.pc_plus, e.pc + 32'(IB));
            chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
            chk("br_pending", 32'(bus.br_pending), 32'(e.pend));
            chk("misalign", 32'(bus.misalign), 32'(e.mis));
            chk("fetch_count", 32'(bus.fetch_count), e.cnt);
        end
    end

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = $urandom;
            1:       t = $urandom & 32'h0000_0FFC;
            2:       t = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
            default: t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        endcase
        return t;
    endfunction

    initial begin
        m_booting = 1'b0;
        m_valid   = 1'b0;
        m_pend    = 1'b0;
        m_mis     = 1'b0;
        m_pc      = '0;
        m_pt      = '0;
        m_cnt     = 0;

        // Reset, boot, sequential fetch up to 0x10, then a taken branch.
        step(1, 0, 0, '0, 0, '0);
        idle(5);
        step(0, 0, 0, '0, 1, 32'h100);
        idle(1);

        // Two branches during a stall: the younger one is applied.
        step(0, 0, 0, '0, 1, 32'h20);
        step(0, 1, 0, '0, 1, 32'h200);
        step(0, 1, 0, '0, 1, 32'h300);
        step(0, 1, 0, '0, 0, '0);
        step(0, 0, 0, '0, 0, '0);
        idle(1);

        // Flush overrides a pending branch and a same-cycle branch.
        step(0, 1, 0, '0, 1, 32'h400);
        step(0, 1, 1, 32'h80, 0, '0);
        step(0, 0, 1, 32'h40, 1, 32'h500);
        idle(1);

        // Address wrap at the top of the space, counter wrap.
        step(0, 0, 0, '0, 1, 32'hFFFF_FFF8);
        idle(20);

        // Misaligned targets on each acceptance path.
        step(0, 0, 0, '0, 1, 32'h102);
        idle(1);
        step(0, 1, 0, '0, 1, 32'h207);
        step(0, 0, 0, '0, 0, '0);
        step(0, 0, 1, 32'h41, 0, '0);
        idle(1);

        // Reset while a branch is pending.
        step(0, 1, 0, '0, 1, 32'h600);
        step(1, 1, 0, '0, 1, 32'h700);
        idle(3);

        for (int i = 0; i < 2000; i++) begin
            bit r, s, fv, bv;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 35);
            fv = ($urandom_range(0, 99) < 6);
            bv = ($urandom_range(0, 99) < 25);
            step(r, s, fv, rnd_target(), bv, rnd_target());
        end

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
